// File: rtl/axi_lite_ipif_bridge.sv
// AXI4-Lite slave to IPIF bridge: one outstanding transaction, alternating
// write/read arbitration and a per-transaction timeout that forces SLVERR.
module axi_lite_ipif_bridge #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_TIMEOUT          = 32
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic                              Bus2IP_Clk,
  output logic                              Bus2IP_Resetn,
  output logic [C_S_AXI_ADDR_WIDTH-1:0]     Bus2IP_Addr,
  output logic                              Bus2IP_CS,
  output logic                              Bus2IP_RNW,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     Bus2IP_Data,
  output logic [C_S_AXI_DATA_WIDTH/8-1:0]   Bus2IP_BE,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     IP2Bus_Data,
  input  logic                              IP2Bus_RdAck,
  input  logic                              IP2Bus_WrAck,
  input  logic                              IP2Bus_Error
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(C_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(C_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WR   = 3'd1,
    RD   = 3'd2,
    BRSP = 3'd3,
    RRSP = 3'd4
  } state_t;

  function automatic logic [1:0] resp_of(input logic err);
    if (err) return 2'b10;
    else     return 2'b00;
  endfunction

  state_t                          state_r;
  logic [CNT_W-1:0]                cnt_r;
  logic                            prefer_wr_r;
  logic                            wr_go_s;
  logic                            rd_go_s;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   addr_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   data_r;
  logic [STRB_W-1:0]               be_r;
  logic                            rnw_r;
  logic                            cs_r;
  logic                            bvalid_r;
  logic [1:0]                      bresp_r;
  logic                            rvalid_r;
  logic [1:0]                      rresp_r;
  logic [C_S_AXI_DATA_WIDTH-1:0]   rdata_r;

  // Acceptance decision in IDLE; on contention the type not served last wins
  always_comb begin
    wr_go_s = 1'b0;
    rd_go_s = 1'b0;
    if ((state_r == IDLE) && S_AXI_ARESETN) begin
      if (S_AXI_AWVALID && S_AXI_WVALID && (prefer_wr_r || !S_AXI_ARVALID)) begin
        wr_go_s = 1'b1;
      end else if (S_AXI_ARVALID) begin
        rd_go_s = 1'b1;
      end else begin
        rd_go_s = 1'b0;
      end
    end else begin
      wr_go_s = 1'b0;
      rd_go_s = 1'b0;
    end
  end

  // Transaction FSM with registered IPIF and response outputs
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      prefer_wr_r <= 1'b1;
      addr_r      <= '0;
      data_r      <= '0;
      be_r        <= '0;
      rnw_r       <= 1'b1;
      cs_r        <= 1'b0;
      bvalid_r    <= 1'b0;
      bresp_r     <= 2'b00;
      rvalid_r    <= 1'b0;
      rresp_r     <= 2'b00;
      rdata_r     <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_go_s) begin
            addr_r      <= S_AXI_AWADDR;
            data_r      <= S_AXI_WDATA;
            be_r        <= S_AXI_WSTRB;
            rnw_r       <= 1'b0;
            cs_r        <= 1'b1;
            cnt_r       <= '0;
            prefer_wr_r <= 1'b0;
            state_r     <= WR;
          end else if (rd_go_s) begin
            addr_r      <= S_AXI_ARADDR;
            rnw_r       <= 1'b1;
            cs_r        <= 1'b1;
            cnt_r       <= '0;
            prefer_wr_r <= 1'b1;
            state_r     <= RD;
          end
        end
        WR: begin
          if (IP2Bus_WrAck) begin
            bresp_r  <= resp_of(IP2Bus_Error);
            bvalid_r <= 1'b1;
            cs_r     <= 1'b0;
            state_r  <= BRSP;
          end else if (cnt_r == CNT_LAST) begin
            bresp_r  <= 2'b10;
            bvalid_r <= 1'b1;
            cs_r     <= 1'b0;
            state_r  <= BRSP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        RD: begin
          // An ack on the final timeout cycle still takes precedence
          if (IP2Bus_RdAck) begin
            rdata_r  <= IP2Bus_Data;
            rresp_r  <= resp_of(IP2Bus_Error);
            rvalid_r <= 1'b1;
            cs_r     <= 1'b0;
            state_r  <= RRSP;
          end else if (cnt_r == CNT_LAST) begin
            rdata_r  <= '0;
            rresp_r  <= 2'b10;
            rvalid_r <= 1'b1;
            cs_r     <= 1'b0;
            state_r  <= RRSP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        BRSP: begin
          if (S_AXI_BREADY) begin
            bvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        RRSP: begin
          if (S_AXI_RREADY) begin
            rvalid_r <= 1'b0;
            state_r  <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          cs_r     <= 1'b0;
          bvalid_r <= 1'b0;
          rvalid_r <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXI_AWREADY = wr_go_s;
  assign S_AXI_WREADY  = wr_go_s;
  assign S_AXI_ARREADY = rd_go_s;
  assign S_AXI_BVALID  = bvalid_r;
  assign S_AXI_BRESP   = bresp_r;
  assign S_AXI_RVALID  = rvalid_r;
  assign S_AXI_RRESP   = rresp_r;
  assign S_AXI_RDATA   = rdata_r;
  assign Bus2IP_Clk    = S_AXI_ACLK;
  assign Bus2IP_Resetn = S_AXI_ARESETN;
  assign Bus2IP_Addr   = addr_r;
  assign Bus2IP_CS     = cs_r;
  assign Bus2IP_RNW    = rnw_r;
  assign Bus2IP_Data   = data_r;
  assign Bus2IP_BE     = be_r;

endmodule

// File: tb/tb_axi_lite_ipif_bridge.sv
// Directed bench for axi_lite_ipif_bridge: vector table of single transactions
// plus hand sequences for arbitration, stray acks and mid-transaction reset.
module tb_axi_lite_ipif_bridge;

  logic        clk;
  logic        rst_n;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        ip_clk;
  logic        ip_resetn;
  logic [31:0] ip_addr;
  logic        ip_cs;
  logic        ip_rnw;
  logic [31:0] ip_wdata;
  logic [3:0]  ip_be;
  logic [31:0] ip_rdata;
  logic        ip_rdack;
  logic        ip_wrack;
  logic        ip_error;

  int n_checks = 0;
  int n_fail   = 0;

  axi_lite_ipif_bridge dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .Bus2IP_Clk(ip_clk), .Bus2IP_Resetn(ip_resetn), .Bus2IP_Addr(ip_addr),
    .Bus2IP_CS(ip_cs), .Bus2IP_RNW(ip_rnw), .Bus2IP_Data(ip_wdata), .Bus2IP_BE(ip_be),
    .IP2Bus_Data(ip_rdata), .IP2Bus_RdAck(ip_rdack), .IP2Bus_WrAck(ip_wrack),
    .IP2Bus_Error(ip_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          delay;
    bit          err;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    int          exp_cs;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int i;
    int cs_cnt;
    @(negedge clk);
    if (v.wr) begin
      awaddr = v.addr; wdata = v.data; wstrb = v.strb;
      awvalid = 1'b1; wvalid = 1'b1;
    end else begin
      araddr = v.addr; arvalid = 1'b1;
    end
    #1;
    chk("awready", awready, v.wr);
    chk("arready", arready, !v.wr);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    chk("cs_on_accept", ip_cs, 1'b1);
    chk("addr", ip_addr, v.addr);
    chk("rnw", ip_rnw, !v.wr);
    if (v.wr) begin
      chk("wdata", ip_wdata, v.data);
      chk("be", ip_be, v.strb);
    end
    ip_rdata = 32'hFFFF_FFFF;
    i = 0; cs_cnt = 0;
    while (ip_cs && i < 100) begin
      cs_cnt++;
      if (i == v.delay) begin
        ip_error = v.err;
        ip_rdata = v.data;
        if (v.wr) ip_wrack = 1'b1;
        else      ip_rdack = 1'b1;
      end
      @(negedge clk);
      ip_wrack = 1'b0; ip_rdack = 1'b0; ip_error = 1'b0; ip_rdata = 32'hFFFF_FFFF;
      i++;
    end
    chk("cs_cycles", cs_cnt, v.exp_cs);
    for (int h = 0; h < 4; h++) begin
      if (v.wr) begin
        chk("bvalid_hold", bvalid, 1'b1);
        chk("bresp", bresp, v.exp_resp);
        chk("rvalid_quiet", rvalid, 1'b0);
      end else begin
        chk("rvalid_hold", rvalid, 1'b1);
        chk("rresp", rresp, v.exp_resp);
        chk("rdata", rdata, v.exp_rdata);
        chk("bvalid_quiet", bvalid, 1'b0);
      end
      @(negedge clk);
    end
    bready = v.wr; rready = !v.wr;
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
    chk("bvalid_done", bvalid, 1'b0);
    chk("rvalid_done", rvalid, 1'b0);
  endtask

  // Ack the current IPIF transaction and complete its response handshake
  task automatic finish_current(input bit wr);
    if (wr) ip_wrack = 1'b1;
    else    ip_rdack = 1'b1;
    ip_rdata = 32'h5A5A_0000;
    @(negedge clk);
    ip_wrack = 1'b0; ip_rdack = 1'b0;
    chk("resp_valid", wr ? bvalid : rvalid, 1'b1);
    chk("resp_other", wr ? rvalid : bvalid, 1'b0);
    bready = wr; rready = !wr;
    #1;
    chk("no_accept_in_rsp", {awready, arready}, 2'b00);
    @(negedge clk);
    bready = 1'b0; rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    awaddr = 32'h0; awvalid = 1'b1; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b1;
    bready = 1'b0; araddr = 32'h0; arvalid = 1'b1; rready = 1'b0;
    ip_rdata = 32'h0; ip_rdack = 1'b0; ip_wrack = 1'b0; ip_error = 1'b0;

    vecs[0] = '{1'b1, 32'h8,  32'hDEADBEEF, 4'hF, 2,    1'b0, 2'b00, 32'h0,        3};
    vecs[1] = '{1'b0, 32'hC,  32'h12345678, 4'h0, 1,    1'b0, 2'b00, 32'h12345678, 2};
    vecs[2] = '{1'b1, 32'h10, 32'hCAFEF00D, 4'h3, 0,    1'b1, 2'b10, 32'h0,        1};
    vecs[3] = '{1'b0, 32'h14, 32'hAAAA5555, 4'h0, 3,    1'b1, 2'b10, 32'hAAAA5555, 4};
    vecs[4] = '{1'b1, 32'h18, 32'h11112222, 4'h8, 1000, 1'b0, 2'b10, 32'h0,        32};
    vecs[5] = '{1'b0, 32'h1C, 32'h33334444, 4'h0, 1000, 1'b0, 2'b10, 32'h0,        32};
    vecs[6] = '{1'b0, 32'h40, 32'h0BADF00D, 4'h0, 31,   1'b0, 2'b00, 32'h0BADF00D, 32};
    vecs[7] = '{1'b1, 32'h44, 32'h76543210, 4'hC, 31,   1'b0, 2'b00, 32'h0,        32};

    // Reset state, with all request valids held high
    repeat (2) @(negedge clk);
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_arready", arready, 1'b0);
    chk("rst_valids", {bvalid, rvalid, ip_cs}, 3'b000);
    chk("rst_resps", {bresp, rresp}, 4'b0000);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_addr", ip_addr, 32'h0);
    chk("rst_data", ip_wdata, 32'h0);
    chk("rst_be", ip_be, 4'h0);
    chk("rst_rnw", ip_rnw, 1'b1);
    chk("rst_resetn", ip_resetn, 1'b0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("resetn_out", ip_resetn, 1'b1);

    // Contention #1 after reset: write wins
    awaddr = 32'h20; wdata = 32'h01020304; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 32'h24; arvalid = 1'b1;
    #1;
    chk("c1_awready", awready, 1'b1);
    chk("c1_arready", arready, 1'b0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("c1_rnw", ip_rnw, 1'b0);
    chk("c1_addr", ip_addr, 32'h20);
    finish_current(1'b1);
    // Contention #2: read wins after a write
    awaddr = 32'h28; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    chk("c2_arready", arready, 1'b1);
    chk("c2_awready", awready, 1'b0);
    @(negedge clk);
    arvalid = 1'b0;
    chk("c2_rnw", ip_rnw, 1'b1);
    chk("c2_addr", ip_addr, 32'h24);
    finish_current(1'b0);
    // Contention #3: write wins again
    araddr = 32'h2C; arvalid = 1'b1;
    #1;
    chk("c3_awready", awready, 1'b1);
    chk("c3_arready", arready, 1'b0);
    @(negedge clk);
    awvalid = 1'b0; wvalid = 1'b0;
    chk("c3_rnw", ip_rnw, 1'b0);
    chk("c3_addr", ip_addr, 32'h28);
    finish_current(1'b1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("c4_rnw", ip_rnw, 1'b1);
    chk("c4_addr", ip_addr, 32'h2C);
    finish_current(1'b0);

    for (int k = 0; k < 8; k++) run_vec(vecs[k]);

    // Stray RdAck in IDLE produces nothing
    @(negedge clk);
    ip_rdack = 1'b1; ip_error = 1'b1; ip_rdata = 32'h99999999;
    @(negedge clk);
    ip_rdack = 1'b0; ip_error = 1'b0;
    chk("stray_rvalid", rvalid, 1'b0);
    chk("stray_cs", ip_cs, 1'b0);
    @(negedge clk);
    chk("stray_rvalid2", rvalid, 1'b0);

    // Reset asserted in the middle of a read
    araddr = 32'h30; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    chk("mid_cs_before", ip_cs, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_cs", ip_cs, 1'b0);
    chk("mid_valids", {bvalid, rvalid}, 2'b00);
    chk("mid_addr", ip_addr, 32'h0);
    @(negedge clk);
    ip_rdack = 1'b1; ip_rdata = 32'h77777777;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      ip_rdack = 1'b0;
      chk("post_rst_rvalid", rvalid, 1'b0);
      chk("post_rst_cs", ip_cs, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_ipif_bridge.md
AXI_LITE_IPIF_BRIDGE -- requirements
Module: axi_lite_ipif_bridge

Interface
REQ-001 Parameters SHALL be:
- C_S_AXI_DATA_WIDTH, 32, data width.
- C_S_AXI_ADDR_WIDTH, 32, address width.
- C_TIMEOUT, 32, Bus2IP cycles allowed before a forced error response (≥2).
REQ-002 Ports SHALL be, clock and reset first:
- S_AXI_ACLK  in  1  sole clock.
- S_AXI_ARESETN  in  1  reset, asynchronous assert, active-low.
- S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
- S_AXI_AWVALID  in  1  write address valid.
- S_AXI_AWREADY  out  1  write address ready.
- S_AXI_WDATA  in  C_S_AXI_DATA_WIDTH  write data.
- S_AXI_WSTRB  in  C_S_AXI_DATA_WIDTH/8  write byte strobes.
- S_AXI_WVALID  in  1  write data valid.
- S_AXI_WREADY  out  1  write data ready.
- S_AXI_BRESP  out  2  write response.
- S_AXI_BVALID  out  1  write response valid.
- S_AXI_BREADY  in  1  write response ready.
- S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
- S_AXI_ARVALID  in  1  read address valid.
- S_AXI_ARREADY  out  1  read address ready.
- S_AXI_RDATA  out  C_S_AXI_DATA_WIDTH  read data.
- S_AXI_RRESP  out  2  read response.
- S_AXI_RVALID  out  1  read data valid.
- S_AXI_RREADY  in  1  read data ready.
- Bus2IP_Clk  out  1  equals S_AXI_ACLK.
- Bus2IP_Resetn  out  1  equals S_AXI_ARESETN.
- Bus2IP_Addr  out  C_S_AXI_ADDR_WIDTH  latched address.
- Bus2IP_CS  out  1  transaction active.
- Bus2IP_RNW  out  1  1 = read.
- Bus2IP_Data  out  C_S_AXI_DATA_WIDTH  latched WDATA.
- Bus2IP_BE  out  C_S_AXI_DATA_WIDTH/8  latched WSTRB.
- IP2Bus_Data  in  C_S_AXI_DATA_WIDTH  read data.
- IP2Bus_RdAck  in  1  read acknowledge.
- IP2Bus_WrAck  in  1  write acknowledge.
- IP2Bus_Error  in  1  error, sampled with an ack.
REQ-003 The block SHALL use one clock, S_AXI_ACLK, and an asynchronous, active-low reset, S_AXI_ARESETN.

Function
REQ-004 The FSM SHALL have the states IDLE, WR, RD, BRSP and RRSP, with exactly one transaction outstanding.
REQ-005 In IDLE, a write SHALL be accepted only when AWVALID and WVALID are both high; AWREADY and WREADY SHALL pulse high together for one cycle, combinationally in IDLE.
REQ-006 In IDLE, a read SHALL be accepted when ARVALID is high; ARREADY SHALL pulse high for one cycle.
REQ-007 When a write and a read are both eligible in IDLE, the type not served last SHALL win; after reset, write wins.
REQ-008 On acceptance, Addr/Data/BE/RNW SHALL be registered and Bus2IP_CS SHALL be high from the next cycle; the FSM SHALL enter WR or RD.
REQ-009 Bus2IP_CS SHALL remain high in WR/RD and SHALL drop on the clock edge after the matching ack is sampled.
REQ-010 In WR, WrAck=1 SHALL cause a move to BRSP, with BRESP = IP2Bus_Error ? 2'b10 : 2'b00.
REQ-011 In RD, RdAck=1 SHALL cause a move to RRSP, with RDATA = IP2Bus_Data and RRESP = IP2Bus_Error ? 2'b10 : 2'b00.
REQ-012 A timeout counter SHALL reset on entry to WR/RD and increment each cycle there.
- At count C_TIMEOUT-1 with no ack, the FSM SHALL leave with SLVERR (2'b10); RDATA SHALL be 0 for reads.
- An ack arriving on that same cycle SHALL win.
REQ-013 Acks not matching the current state, including any ack in IDLE, BRSP or RRSP, SHALL be ignored.
REQ-014 BVALID SHALL be high only in BRSP, and RVALID only in RRSP; each SHALL hold until the corresponding READY is sampled high, then return to IDLE.
REQ-015 A new transaction SHALL NOT be accepted on the same cycle a response completes; the earliest accept is the next cycle in IDLE.
REQ-016 RDATA, RRESP and BRESP SHALL remain stable while their VALID is high and unacknowledged.

Reset
REQ-017 While S_AXI_ARESETN is low, and asynchronously on its assertion:
- state = IDLE, timeout = 0.
- All READY/VALID outputs and Bus2IP_CS = 0.
- BRESP/RRESP = 2'b00.
- RDATA, Bus2IP_Addr, Bus2IP_Data = 0; Bus2IP_BE = 0; Bus2IP_RNW = 1.
- Write-priority flag favours write.
REQ-018 A reset during WR, RD, BRSP or RRSP SHALL abandon the transaction without issuing any response.

Verification
REQ-019 Write: AWADDR=0x8, WDATA=0xDEADBEEF, WSTRB=0xF, WrAck 2 cycles after CS -> CS high for 3 cycles with Addr=0x8 and Data=0xDEADBEEF; BVALID with BRESP=00.
REQ-020 Read: ARADDR=0xC, RdAck with Data=0x12345678 -> RVALID with RDATA=0x12345678 and RRESP=00, held for 4 cycles with RREADY low.
REQ-021 Simultaneous AW/W/AR valid after reset -> write served first, read next; alternation continues on repeated contention.
REQ-022 No ack, C_TIMEOUT=32 -> CS drops after 32 cycles; SLVERR with RDATA=0 for a read.
REQ-023 IP2Bus_Error=1 with WrAck -> BRESP=10; a stray RdAck pulse in IDLE causes no RVALID.
REQ-024 Reset asserted mid-RD -> CS and all VALIDs low immediately; no RVALID after release.
